// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_monitor
// Description : Samples an externally generated divided clock in the clk
//               domain, measures its period and high time, checks the period
//               against an expected value and reports lock, loss of lock and
//               stalled-clock conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_monitor #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 5,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_EXP_PERIOD = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] c_TOL        = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] c_TIMEOUT    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};
    localparam int               c_MC_W       = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [c_MC_W-1:0] c_MC_LAST   = c_MC_W'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    logic              r_s1;
    logic              r_s2;
    logic              r_s3;
    logic              w_rise;
    logic [CNT_W-1:0]  r_per_cnt;
    logic [CNT_W-1:0]  r_high_cnt;
    logic [CNT_W-1:0]  w_diff;
    logic              w_match;
    logic              w_timeout;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_MC_W-1:0] r_match_cnt;
    logic [c_MC_W-1:0] w_match_cnt_nxt;
    logic              w_err_nxt;
    logic              w_meas;

    // Three-flop synchronizer; the third stage only serves edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= div_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // Period and high-time counters restart at 1 on each rising edge and saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt  <= '0;
            r_high_cnt <= '0;
        end else if (w_rise) begin
            r_per_cnt  <= CNT_W'(1);
            r_high_cnt <= CNT_W'(1);
        end else begin
            if (r_per_cnt != c_CNT_MAX) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
            end
            if (r_s2 && (r_high_cnt != c_CNT_MAX)) begin
                r_high_cnt <= r_high_cnt + CNT_W'(1);
            end
        end
    end

    // Absolute deviation of the running period from the expected one.
    assign w_diff    = (r_per_cnt >= c_EXP_PERIOD) ? (r_per_cnt - c_EXP_PERIOD)
                                                   : (c_EXP_PERIOD - r_per_cnt);
    assign w_match   = (w_diff <= c_TOL);
    assign w_timeout = (r_per_cnt == c_TIMEOUT);

    // State and consecutive-match counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_match_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_cnt_nxt;
        end
    end

    // Next-state logic; a rise always takes priority over a coincident timeout.
    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_err_nxt       = 1'b0;
        w_meas          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt     = ST_ACQ;
                    w_match_cnt_nxt = '0;
                end
            end
            ST_ACQ: begin
                if (w_rise) begin
                    w_meas = 1'b1;
                    if (w_match && (r_match_cnt == c_MC_LAST)) begin
                        w_state_nxt     = ST_LOCK;
                        w_match_cnt_nxt = '0;
                    end else if (w_match) begin
                        w_match_cnt_nxt = r_match_cnt + c_MC_W'(1);
                    end else begin
                        w_match_cnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt     = ST_IDLE;
                    w_match_cnt_nxt = '0;
                end
            end
            ST_LOCK: begin
                if (w_rise) begin
                    w_meas = 1'b1;
                    if (!w_match) begin
                        w_err_nxt       = 1'b1;
                        w_state_nxt     = ST_ACQ;
                        w_match_cnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_err_nxt       = 1'b1;
                    w_state_nxt     = ST_IDLE;
                    w_match_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_match_cnt_nxt = '0;
            end
        endcase
    end

    // Registered outputs; measurements latch the pre-update counter values.
    always_ff @(posedge clk) begin
        if (rst) begin
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            period_valid <= w_meas;
            err          <= w_err_nxt;
            locked       <= (w_state_nxt == ST_LOCK);
            if (w_meas) begin
                period    <= r_per_cnt;
                high_time <= r_high_cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_monitor
// Description : Directed self-checking bench for clk_div_monitor. Instance A
//               uses TOL=0, instance B uses TOL=1; both share clk and rst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_monitor;

    localparam int c_CNT_W = 16;

    logic               clk;
    logic               rst;
    logic               div_in_a;
    logic               div_in_b;
    logic [c_CNT_W-1:0] period_a;
    logic [c_CNT_W-1:0] high_time_a;
    logic               period_valid_a;
    logic               locked_a;
    logic               err_a;
    logic [c_CNT_W-1:0] period_b;
    logic [c_CNT_W-1:0] high_time_b;
    logic               period_valid_b;
    logic               locked_b;
    logic               err_b;

    int  n_chk  = 0;
    int  n_pass = 0;
    bit  sel    = 1'b0;

    clk_div_monitor #(
        .CNT_W(c_CNT_W), .EXP_PERIOD(5), .TOL(0), .LOCK_CNT(4), .TIMEOUT(20)
    ) u_dut_a (
        .clk(clk), .rst(rst), .div_in(div_in_a),
        .period(period_a), .high_time(high_time_a),
        .period_valid(period_valid_a), .locked(locked_a), .err(err_a)
    );

    clk_div_monitor #(
        .CNT_W(c_CNT_W), .EXP_PERIOD(5), .TOL(1), .LOCK_CNT(4), .TIMEOUT(20)
    ) u_dut_b (
        .clk(clk), .rst(rst), .div_in(div_in_b),
        .period(period_b), .high_time(high_time_b),
        .period_valid(period_valid_b), .locked(locked_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive the selected instance for one clk cycle, then sample #1 after the edge.
    task automatic cyc(input bit d);
        div_in_a = sel ? 1'b0 : d;
        div_in_b = sel ? d : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input bit pv, input int per,
                            input int ht, input bit lk, input bit er);
        if (sel) begin
            chk({tag, ".pv"},  32'(period_valid_b), 32'(pv));
            chk({tag, ".per"}, 32'(period_b),       32'(per));
            chk({tag, ".ht"},  32'(high_time_b),    32'(ht));
            chk({tag, ".lk"},  32'(locked_b),       32'(lk));
            chk({tag, ".err"}, 32'(err_b),          32'(er));
        end else begin
            chk({tag, ".pv"},  32'(period_valid_a), 32'(pv));
            chk({tag, ".per"}, 32'(period_a),       32'(per));
            chk({tag, ".ht"},  32'(high_time_a),    32'(ht));
            chk({tag, ".lk"},  32'(locked_a),       32'(lk));
            chk({tag, ".err"}, 32'(err_a),          32'(er));
        end
    endtask

    // One div_in period of h high and l low cycles. The rise launched by its
    // first high cycle shows on the outputs after the third cycle.
    task automatic run_period(input int h, input int l, input bit pv, input int per,
                              input int ht, input bit lk, input bit er, input string tag);
        for (int i = 0; i < h + l; i++) begin
            cyc(i < h);
            if (i == 2) chk_outs(tag, pv, per, ht, lk, er);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        div_in_a = 1'b0;
        div_in_b = 1'b0;

        // Reset state of both instances
        do_reset();
        sel = 1'b0;
        chk_outs("rst_a", 0, 0, 0, 0, 0);
        sel = 1'b1;
        chk_outs("rst_b", 0, 0, 0, 0, 0);

        // Nominal lock: 2 high / 3 low
        sel = 1'b0;
        run_period(2, 3, 0, 0, 0, 0, 0, "nom_r1");
        run_period(2, 3, 1, 5, 2, 0, 0, "nom_r2");
        run_period(2, 3, 1, 5, 2, 0, 0, "nom_r3");
        run_period(2, 3, 1, 5, 2, 0, 0, "nom_r4");
        run_period(2, 3, 1, 5, 2, 1, 0, "nom_r5");

        // Glitch while locked: one period of 6, then relock over 4 periods of 5
        run_period(2, 4, 1, 5, 2, 1, 0, "glt_r6");
        run_period(2, 3, 1, 6, 2, 0, 1, "glt_err");
        run_period(2, 3, 1, 5, 2, 0, 0, "glt_r8");
        run_period(2, 3, 1, 5, 2, 0, 0, "glt_r9");
        run_period(2, 3, 1, 5, 2, 0, 0, "glt_r10");
        run_period(2, 3, 1, 5, 2, 1, 0, "glt_relock");

        // Stall: per_cnt reaches 20 after 17 further low cycles
        repeat (17) cyc(1'b0);
        chk("stl_pre.lk",  32'(locked_a), 32'd1);
        chk("stl_pre.err", 32'(err_a),    32'd0);
        cyc(1'b0);
        chk("stl_to.err", 32'(err_a),    32'd1);
        chk("stl_to.lk",  32'(locked_a), 32'd0);
        cyc(1'b0);
        chk("stl_post.err", 32'(err_a), 32'd0);
        run_period(2, 3, 0, 5, 2, 0, 0, "stl_r1");
        run_period(2, 3, 1, 5, 2, 0, 0, "stl_r2");

        // Reset mid-acquisition after the 3rd rise
        do_reset();
        run_period(2, 3, 0, 0, 0, 0, 0, "rma_r1");
        run_period(2, 3, 1, 5, 2, 0, 0, "rma_r2");
        run_period(2, 3, 1, 5, 2, 0, 0, "rma_r3");
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        chk_outs("rma_rst", 0, 0, 0, 0, 0);
        run_period(2, 3, 0, 0, 0, 0, 0, "rma_n1");
        run_period(2, 3, 1, 5, 2, 0, 0, "rma_n2");
        run_period(2, 3, 1, 5, 2, 0, 0, "rma_n3");
        run_period(2, 3, 1, 5, 2, 0, 0, "rma_n4");
        run_period(2, 3, 1, 5, 2, 1, 0, "rma_n5");

        // Reset released while div_in is high
        rst = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        rst = 1'b0;
        chk_outs("rhi_rst", 0, 0, 0, 0, 0);
        run_period(2, 3, 0, 0, 0, 0, 0, "rhi_r1");
        run_period(2, 3, 1, 5, 2, 0, 0, "rhi_r2");

        // Tolerance on instance B: alternate 4 and 6, then a 7 breaks lock
        do_reset();
        sel = 1'b1;
        run_period(2, 2, 0, 0, 0, 0, 0, "tol_r1");
        run_period(2, 4, 1, 4, 2, 0, 0, "tol_r2");
        run_period(2, 2, 1, 6, 2, 0, 0, "tol_r3");
        run_period(2, 4, 1, 4, 2, 0, 0, "tol_r4");
        run_period(2, 5, 1, 6, 2, 1, 0, "tol_r5");
        run_period(2, 3, 1, 7, 2, 0, 1, "tol_r6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
